tug_field: RTL

- Playfield engine for the Cyber War tug-of-war game.
- Owns the single lit position on the light bar and conditions the two raw player keys into one-cycle press pulses.
- Drives the edge-status levels and press pulses consumed by the score counter block.
- Takes that block's round-restart request back, re-centring the light and re-arming play.

---
 rtl/tug_field_pkg.sv | 18 +
 rtl/tug_field_key_cond.sv | 57 +++++
 rtl/tug_field.sv | 99 +++++++++
 3 files changed

// File: rtl/tug_field_pkg.sv
// Shared types and sizing helpers for the tug-of-war playfield.
package field_pkg;

  typedef enum logic {S_ARM = 1'b0, S_PLAY = 1'b1} field_state_e;

  localparam int N_LIGHTS_DEF = 9;

  function automatic int centre(input int n);
    return n / 2;
  endfunction

  function automatic int pos_w(input int n);
    return $clog2(n);
  endfunction

  localparam int POS_W_DEF = pos_w(N_LIGHTS_DEF);

endpackage

// File: rtl/tug_field_key_cond.sv
// Raw key conditioning: synchroniser, optional debounce (FIELD_DEBOUNCE_EN), rise detect.
module key_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic level,
  output logic rise
);

  if (SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_cfg
    $error("key_cond: SYNC_STAGES must be >= 2 and DEB_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], key};
  end

`ifdef FIELD_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          acc;

  // Counter runs only while the synchronised sample disagrees with the accepted level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == acc) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      acc <= sync[SYNC_STAGES-1];
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign level = acc;
`else
  assign level = sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/tug_field.sv
// Tug-of-war playfield: one lit position, press pulses, round re-arm.
// Optional key debounce is enabled by defining FIELD_DEBOUNCE_EN.
module tug_field
  import field_pkg::*;
#(
  parameter int N_LIGHTS    = 9,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_l,
  input  logic                key_r,
  input  logic                round_rst,
  output logic [N_LIGHTS-1:0] lights,
  output logic                l_press,
  output logic                r_press,
  output logic                le,
  output logic                re
);

  localparam int                  POS_W  = pos_w(N_LIGHTS);
  localparam logic [POS_W-1:0]    CENTRE = POS_W'(centre(N_LIGHTS));
  localparam logic [POS_W-1:0]    LAST   = POS_W'(N_LIGHTS - 1);
  localparam logic [N_LIGHTS-1:0] ONE    = N_LIGHTS'(1);

  if (N_LIGHTS < 3 || (N_LIGHTS % 2) == 0) begin : g_bad_cfg
    $error("tug_field: N_LIGHTS must be odd and >= 3");
  end

  // Index 1 = left key, index 0 = right key.
  logic [1:0] keys, lvl, rise;
  assign keys = {key_l, key_r};

  for (genvar g = 0; g < 2; g++) begin : g_key
    key_cond #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_key (
      .clk  (clk),
      .reset(reset),
      .key  (keys[g]),
      .level(lvl[g]),
      .rise (rise[g])
    );
  end

  field_state_e     state, state_nxt;
  logic [POS_W-1:0] pos, pos_nxt;
  logic             l_press_nxt, r_press_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_ARM;
      pos     <= CENTRE;
      l_press <= 1'b0;
      r_press <= 1'b0;
    end else begin
      state   <= state_nxt;
      pos     <= pos_nxt;
      l_press <= l_press_nxt;
      r_press <= r_press_nxt;
    end
  end

  // The light moves on the cycle after its press pulse, so the counter
  // sees the pre-move edge level alongside the pulse and only scores a
  // press made while the edge was already lit.
  always_comb begin
    state_nxt   = state;
    pos_nxt     = pos;
    l_press_nxt = 1'b0;
    r_press_nxt = 1'b0;
    case (state)
      S_PLAY: begin
        if (round_rst) begin
          pos_nxt   = CENTRE;
          state_nxt = S_ARM;
        end else begin
          l_press_nxt = rise[1];
          r_press_nxt = rise[0];
          if (l_press && !r_press && pos != LAST)
            pos_nxt = pos + POS_W'(1);
          else if (r_press && !l_press && pos != '0)
            pos_nxt = pos - POS_W'(1);
        end
      end
      default: begin
        pos_nxt = CENTRE;
        if (!round_rst && !lvl[1] && !lvl[0]) state_nxt = S_PLAY;
      end
    endcase
  end

  assign lights = ONE << pos;
  assign le     = lights[N_LIGHTS-1];
  assign re     = lights[0];

endmodule
